// File: rtl/mux_6_to_1_5bits_seq_pkg.sv
// Shared definitions for the 6-to-1 sequential lane mux.
//   DATA_W / LANES / SEL_W : lane width, lane count, lane-index width
//   state_e                : controller states
//   LANE_1 .. LANE_6       : lane index encoding, matching the 1-to-6 demux select
package mux_6_to_1_5bits_seq_pkg;

    localparam int unsigned DATA_W = 5;
    localparam int unsigned LANES  = 6;
    localparam int unsigned SEL_W  = 3;

    typedef logic [DATA_W-1:0] lane_t;
    typedef logic [LANES-1:0]  mask_t;
    typedef logic [SEL_W-1:0]  sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam sel_t LANE_1 = 3'd0;
    localparam sel_t LANE_2 = 3'd1;
    localparam sel_t LANE_3 = 3'd2;
    localparam sel_t LANE_4 = 3'd3;
    localparam sel_t LANE_5 = 3'd4;
    localparam sel_t LANE_6 = 3'd5;

endpackage

// File: rtl/mux_6_to_1_5bits_seq_if.sv
// Frame-in / beat-out bus of the 6-to-1 sequential lane mux.
//   master : frame source and beat sink (drives lanes, mask, load, dout_ready)
//   slave  : the mux itself (drives load_ready, dout, dout_sel, dout_valid, frame_done)
interface mux_6_to_1_5bits_seq_if
    import mux_6_to_1_5bits_seq_pkg::*;
    ;

    lane_t din_1;
    lane_t din_2;
    lane_t din_3;
    lane_t din_4;
    lane_t din_5;
    lane_t din_6;
    mask_t din_mask;
    logic  load;
    logic  load_ready;
    lane_t dout;
    sel_t  dout_sel;
    logic  dout_valid;
    logic  dout_ready;
    logic  frame_done;

    modport master (
        output din_1, din_2, din_3, din_4, din_5, din_6,
        output din_mask, load, dout_ready,
        input  load_ready, dout, dout_sel, dout_valid, frame_done
    );

    modport slave (
        input  din_1, din_2, din_3, din_4, din_5, din_6,
        input  din_mask, load, dout_ready,
        output load_ready, dout, dout_sel, dout_valid, frame_done
    );

endinterface

// File: rtl/mux_6_to_1_5bits_seq_prio_pick_6.sv
// Lowest-set-bit picker over a 6-bit lane mask (purely combinational).
//   mask : candidate lanes, bit k-1 = lane k
//   idx  : index of the lowest set bit (0 when mask is empty)
//   any  : mask has at least one bit set
//   rest : mask with the picked bit cleared
module prio_pick_6
    import mux_6_to_1_5bits_seq_pkg::*;
(
    input  mask_t mask,
    output sel_t  idx,
    output logic  any,
    output mask_t rest
);

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        rest = mask;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (!any && mask[i]) begin
                any     = 1'b1;
                idx     = sel_t'(i);
                rest[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_6_to_1_5bits_seq.sv
// Sequential 6-to-1 lane mux: captures six 5-bit lanes plus a lane-valid mask
// as one frame, then emits the masked-in lanes lowest first, one beat per
// dout_valid/dout_ready handshake, tagging each beat with its lane index.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of mux_6_to_1_5bits_seq_if (lanes, mask, load,
//                load_ready, dout, dout_sel, dout_valid, dout_ready, frame_done)
module mux_6_to_1_5bits_seq
    import mux_6_to_1_5bits_seq_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    mux_6_to_1_5bits_seq_if.slave    bus
);

    state_e state_q, state_d;
    lane_t  data_q [LANES];
    lane_t  data_d [LANES];
    // Holds lanes still to be presented, excluding the beat on dout; the
    // current lane's bit is cleared when it is loaded onto dout, so the
    // advance picker sees only the remaining lanes.
    mask_t  pend_q, pend_d;
    lane_t  dout_q, dout_d;
    sel_t   sel_q,  sel_d;
    logic   fd_q,   fd_d;

    lane_t  din_arr [LANES];

    sel_t   ld_idx,  adv_idx;
    logic   ld_any,  adv_any;
    mask_t  ld_rest, adv_rest;

    logic   load_ready;
    logic   load_acc;
    logic   beat_acc;

    always_comb begin
        din_arr[0] = bus.din_1;
        din_arr[1] = bus.din_2;
        din_arr[2] = bus.din_3;
        din_arr[3] = bus.din_4;
        din_arr[4] = bus.din_5;
        din_arr[5] = bus.din_6;
    end

    prio_pick_6 u_pick_load (
        .mask (bus.din_mask),
        .idx  (ld_idx),
        .any  (ld_any),
        .rest (ld_rest)
    );

    prio_pick_6 u_pick_adv (
        .mask (pend_q),
        .idx  (adv_idx),
        .any  (adv_any),
        .rest (adv_rest)
    );

    // A last beat being accepted frees the slot in the same cycle, which is
    // what allows back-to-back frames without a bubble.
    assign load_ready = (state_q == IDLE) ||
                        ((state_q == SEND) && !adv_any && bus.dout_ready);
    assign load_acc   = bus.load && load_ready && ld_any;
    assign beat_acc   = (state_q == SEND) && bus.dout_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        pend_d  = pend_q;
        dout_d  = dout_q;
        sel_d   = sel_q;
        fd_d    = 1'b0;

        if (beat_acc) begin
            if (adv_any) begin
                sel_d  = adv_idx;
                dout_d = data_q[adv_idx];
                pend_d = adv_rest;
            end else begin
                state_d = IDLE;
                fd_d    = 1'b1;
            end
        end

        // A new frame overrides the return to IDLE; frame_done for the old
        // frame is still raised above.
        if (load_acc) begin
            state_d = SEND;
            data_d  = din_arr;
            pend_d  = ld_rest;
            sel_d   = ld_idx;
            dout_d  = din_arr[ld_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '{default: '0};
            pend_q  <= '0;
            dout_q  <= '0;
            sel_q   <= LANE_1;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            dout_q  <= dout_d;
            sel_q   <= sel_d;
            fd_q    <= fd_d;
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.dout       = dout_q;
    assign bus.dout_sel   = sel_q;
    assign bus.dout_valid = (state_q == SEND);
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_mux_6_to_1_5bits_seq.sv
module tb_mux_6_to_1_5bits_seq;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    mux_6_to_1_5bits_seq_if bus ();

    mux_6_to_1_5bits_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_beat(input string tag, input logic v, input logic [4:0] d, input logic [2:0] s);
        chk({tag, ".valid"}, 32'(bus.dout_valid), 32'(v));
        chk({tag, ".dout"},  32'(bus.dout),       32'(d));
        chk({tag, ".sel"},   32'(bus.dout_sel),   32'(s));
    endtask

    task automatic chk_fd(input string tag, input logic e);
        chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'(e));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                             input logic [4:0] d, input logic [4:0] e, input logic [4:0] f);
        bus.din_1 = a; bus.din_2 = b; bus.din_3 = c;
        bus.din_4 = d; bus.din_5 = e; bus.din_6 = f;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        set_lanes(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        bus.din_mask   = 6'b0;
        bus.load       = 1'b0;
        bus.dout_ready = 1'b0;
        #12;
        // reset state
        chk_beat("rst", 1'b0, 5'd0, 3'd0);
        chk_fd("rst", 1'b0);
        chk("rst.load_ready", 32'(bus.load_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // full frame, lanes 1..6
        set_lanes(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6);
        bus.din_mask   = 6'b111111;
        bus.load       = 1'b1;
        bus.dout_ready = 1'b1;
        tick();
        bus.load = 1'b0;
        chk_beat("full.b1", 1'b1, 5'd1, 3'd0);
        chk_fd("full.b1", 1'b0);
        tick(); chk_beat("full.b2", 1'b1, 5'd2, 3'd1);
        tick(); chk_beat("full.b3", 1'b1, 5'd3, 3'd2);
        tick(); chk_beat("full.b4", 1'b1, 5'd4, 3'd3);
        tick(); chk_beat("full.b5", 1'b1, 5'd5, 3'd4);
        tick(); chk_beat("full.b6", 1'b1, 5'd6, 3'd5);
        chk_fd("full.b6", 1'b0);
        tick();
        chk_beat("full.end", 1'b0, 5'd6, 3'd5);
        chk_fd("full.end", 1'b1);
        chk("full.end.load_ready", 32'(bus.load_ready), 32'd1);
        tick();
        chk_fd("full.after", 1'b0);

        // sparse mask 100101
        set_lanes(5'd17, 5'd3, 5'd9, 5'd4, 5'd5, 5'd31);
        bus.din_mask = 6'b100101;
        bus.load     = 1'b1;
        tick();
        bus.load = 1'b0;
        chk_beat("sparse.b1", 1'b1, 5'd17, 3'd0);
        tick(); chk_beat("sparse.b2", 1'b1, 5'd9, 3'd2);
        tick(); chk_beat("sparse.b3", 1'b1, 5'd31, 3'd5);
        tick();
        chk_beat("sparse.end", 1'b0, 5'd31, 3'd5);
        chk_fd("sparse.end", 1'b1);
        tick();

        // back-pressure during beat 1 of a two-lane frame
        set_lanes(5'd10, 5'd20, 5'd0, 5'd0, 5'd0, 5'd0);
        bus.din_mask   = 6'b000011;
        bus.load       = 1'b1;
        bus.dout_ready = 1'b0;
        tick();
        bus.load = 1'b0;
        chk_beat("stall.c1", 1'b1, 5'd10, 3'd0);
        chk("stall.load_ready", 32'(bus.load_ready), 32'd0);
        tick(); chk_beat("stall.c2", 1'b1, 5'd10, 3'd0);
        tick(); chk_beat("stall.c3", 1'b1, 5'd10, 3'd0);
        chk_fd("stall.c3", 1'b0);
        bus.dout_ready = 1'b1;
        #1;
        chk("stall.notlast.load_ready", 32'(bus.load_ready), 32'd0);
        tick();
        chk_beat("stall.b2", 1'b1, 5'd20, 3'd1);
        chk("stall.last.load_ready", 32'(bus.load_ready), 32'd1);
        bus.dout_ready = 1'b0;
        #1;
        chk("stall.last.noready.load_ready", 32'(bus.load_ready), 32'd0);
        tick();
        chk_beat("stall.b2hold", 1'b1, 5'd20, 3'd1);
        bus.dout_ready = 1'b1;
        tick();
        chk_beat("stall.end", 1'b0, 5'd20, 3'd1);
        chk_fd("stall.end", 1'b1);
        tick();

        // back-to-back frames
        set_lanes(5'd11, 5'd12, 5'd0, 5'd0, 5'd0, 5'd0);
        bus.din_mask = 6'b000011;
        bus.load     = 1'b1;
        tick();
        bus.load = 1'b0;
        chk_beat("b2b.b1", 1'b1, 5'd11, 3'd0);
        tick();
        chk_beat("b2b.b2", 1'b1, 5'd12, 3'd1);
        set_lanes(5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        bus.din_mask = 6'b000001;
        bus.load     = 1'b1;
        #1;
        chk("b2b.load_ready", 32'(bus.load_ready), 32'd1);
        tick();
        bus.load = 1'b0;
        chk_beat("b2b.new", 1'b1, 5'd7, 3'd0);
        chk_fd("b2b.new", 1'b1);
        tick();
        chk_beat("b2b.end", 1'b0, 5'd7, 3'd0);
        chk_fd("b2b.end", 1'b1);
        tick();
        chk_fd("b2b.after", 1'b0);

        // empty-mask load ignored, then load during SEND ignored
        set_lanes(5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26);
        bus.din_mask = 6'b000000;
        bus.load     = 1'b1;
        tick();
        bus.load = 1'b0;
        chk_beat("nomask", 1'b0, 5'd7, 3'd0);
        chk_fd("nomask", 1'b0);
        chk("nomask.load_ready", 32'(bus.load_ready), 32'd1);
        set_lanes(5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0);
        bus.din_mask = 6'b000111;
        bus.load     = 1'b1;
        tick();
        chk_beat("ign.b1", 1'b1, 5'd1, 3'd0);
        set_lanes(5'd30, 5'd30, 5'd30, 5'd30, 5'd30, 5'd30);
        bus.din_mask = 6'b111111;
        chk("ign.load_ready", 32'(bus.load_ready), 32'd0);
        tick();
        chk_beat("ign.b2", 1'b1, 5'd2, 3'd1);
        bus.load = 1'b0;
        tick();
        chk_beat("ign.b3", 1'b1, 5'd3, 3'd2);
        tick();
        chk_beat("ign.end", 1'b0, 5'd3, 3'd2);
        chk_fd("ign.end", 1'b1);
        tick();

        // reset mid-frame after beat 2
        set_lanes(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6);
        bus.din_mask = 6'b111111;
        bus.load     = 1'b1;
        tick();
        bus.load = 1'b0;
        chk_beat("abort.b1", 1'b1, 5'd1, 3'd0);
        tick();
        chk_beat("abort.b2", 1'b1, 5'd2, 3'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_beat("abort.rst", 1'b0, 5'd0, 3'd0);
        chk_fd("abort.rst", 1'b0);
        chk("abort.load_ready", 32'(bus.load_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        chk_beat("abort.after", 1'b0, 5'd0, 3'd0);
        chk_fd("abort.after", 1'b0);
        tick();
        chk_fd("abort.after2", 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
